alu_exec_unit: RTL

Multi-cycle RV64 integer execution unit that consumes the 5-bit ALU control code produced by the ALU decoder, together with two operands, and returns a registered 64-bit result. Sits in the execute stage between operand select and writeback. Uses a valid/ready handshake on both sides so the datapath can stall while a shift iterates.

---
 rtl/alu_exec_unit.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   RV64 integer execute unit. Takes the 5-bit ALU control code and two
//   operands and returns a registered 64-bit result. Both sides use a
//   valid/ready handshake, so the unit can hold off new requests while a
//   shift iterates one bit per cycle.
//
// Build option:
//   ALU_FAST_SHIFT_EN  defined   -> single-cycle barrel shifter, every op has latency 1
//                      undefined -> iterative shifter, latency 1 + shift amount
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_alu_control      operation code, sampled on accept
//   i_src_a, i_src_b   operands (shift amount in b[5:0], b[4:0] for W shifts)
//   i_valid / o_ready  request handshake
//   o_result, o_zero   result and result==0 flag, valid while o_valid
//   o_valid / i_ready  result handshake
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no result held, ready for a request
// ST_SHIFT | shifting the working register one bit per cycle (iterative build only)
// ST_DONE  | result presented on o_result until the consumer takes it

module alu_exec_unit #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [4:0]            i_alu_control,
    input  logic [DATA_WIDTH-1:0] i_src_a,
    input  logic [DATA_WIDTH-1:0] i_src_b,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_result,
    output logic                  o_zero,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;
    localparam logic [4:0] OP_AND   = 5'b00010;
    localparam logic [4:0] OP_OR    = 5'b00011;
    localparam logic [4:0] OP_XOR   = 5'b00100;
    localparam logic [4:0] OP_SLL   = 5'b00101;
    localparam logic [4:0] OP_SLT   = 5'b00110;
    localparam logic [4:0] OP_SLTU  = 5'b00111;
    localparam logic [4:0] OP_SRL   = 5'b01000;
    localparam logic [4:0] OP_SRA   = 5'b01001;
    localparam logic [4:0] OP_ADDW  = 5'b01010;
    localparam logic [4:0] OP_SUBW  = 5'b01011;
    localparam logic [4:0] OP_SLLW  = 5'b01100;
    localparam logic [4:0] OP_SRLW  = 5'b01101;
    localparam logic [4:0] OP_SRAW  = 5'b01110;
    localparam logic [4:0] OP_ADDIW = 5'b01111;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic {ST_IDLE, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_DONE, ST_SHIFT} state_t;
`endif

    state_t      state_q;
    logic        valid_q;
    logic [63:0] result_q;
    logic        zero_q;

    logic        accept;
    logic [31:0] sum32_d;
    logic [31:0] diff32_d;
    logic [63:0] alu_res_d;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    assign o_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & i_ready);
    assign accept   = i_valid & o_ready;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_zero   = zero_q;

`ifdef ALU_FAST_SHIFT_EN
    logic [31:0] sll32_d;
    logic [31:0] srl32_d;
    logic [31:0] sra32_d;

    always_comb begin
        sll32_d = i_src_a[31:0] << i_src_b[4:0];
        srl32_d = i_src_a[31:0] >> i_src_b[4:0];
        sra32_d = $signed(i_src_a[31:0]) >>> i_src_b[4:0];
    end
`else
    logic        is_w_shift_d;
    logic        is_shift_d;
    logic [5:0]  shamt_d;
    logic [63:0] preload_d;
    logic        start_shift;

    logic [63:0] work_q;
    logic [5:0]  cnt_q;
    logic        left_q;
    logic        arith_q;
    logic        w_q;
    logic [63:0] step_d;
    logic [63:0] step_final_d;

    always_comb begin
        is_w_shift_d = (i_alu_control == OP_SLLW) | (i_alu_control == OP_SRLW) |
                       (i_alu_control == OP_SRAW);
        is_shift_d   = is_w_shift_d | (i_alu_control == OP_SLL) |
                       (i_alu_control == OP_SRL) | (i_alu_control == OP_SRA);
        shamt_d      = is_w_shift_d ? {1'b0, i_src_b[4:0]} : i_src_b[5:0];
        start_shift  = is_shift_d & (shamt_d != 6'd0);

        // W right shifts run on the full 64-bit register, so the upper half is
        // pre-filled to make bit 63 behave like bit 31 of the 32-bit operand.
        preload_d = i_src_a;
        if (i_alu_control == OP_SRLW) begin
            preload_d = {32'd0, i_src_a[31:0]};
        end else if (i_alu_control == OP_SRAW) begin
            preload_d = sext32(i_src_a[31:0]);
        end
    end

    always_comb begin
        if (left_q) begin
            step_d = {work_q[62:0], 1'b0};
        end else begin
            step_d = {arith_q & work_q[63], work_q[63:1]};
        end
        step_final_d = w_q ? sext32(step_d[31:0]) : step_d;
    end
`endif

    always_comb begin
        sum32_d   = i_src_a[31:0] + i_src_b[31:0];
        diff32_d  = i_src_a[31:0] - i_src_b[31:0];
        alu_res_d = '0;
        case (i_alu_control)
            OP_ADD:            alu_res_d = i_src_a + i_src_b;
            OP_SUB:            alu_res_d = i_src_a - i_src_b;
            OP_AND:            alu_res_d = i_src_a & i_src_b;
            OP_OR:             alu_res_d = i_src_a | i_src_b;
            OP_XOR:            alu_res_d = i_src_a ^ i_src_b;
            OP_SLT:            alu_res_d = {63'd0, $signed(i_src_a) < $signed(i_src_b)};
            OP_SLTU:           alu_res_d = {63'd0, i_src_a < i_src_b};
            OP_ADDW, OP_ADDIW: alu_res_d = sext32(sum32_d);
            OP_SUBW:           alu_res_d = sext32(diff32_d);
`ifdef ALU_FAST_SHIFT_EN
            OP_SLL:            alu_res_d = i_src_a << i_src_b[5:0];
            OP_SRL:            alu_res_d = i_src_a >> i_src_b[5:0];
            OP_SRA:            alu_res_d = $signed(i_src_a) >>> i_src_b[5:0];
            OP_SLLW:           alu_res_d = sext32(sll32_d);
            OP_SRLW:           alu_res_d = sext32(srl32_d);
            OP_SRAW:           alu_res_d = sext32(sra32_d);
`else
            // Only reached with a zero shift amount; non-zero amounts go to ST_SHIFT.
            OP_SLL, OP_SRL, OP_SRA:    alu_res_d = i_src_a;
            OP_SLLW, OP_SRLW, OP_SRAW: alu_res_d = sext32(i_src_a[31:0]);
`endif
            default:           alu_res_d = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            work_q   <= '0;
            cnt_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            w_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
                        if (start_shift) begin
                            state_q <= ST_SHIFT;
                            valid_q <= 1'b0;
                            work_q  <= preload_d;
                            cnt_q   <= shamt_d;
                            left_q  <= (i_alu_control == OP_SLL) | (i_alu_control == OP_SLLW);
                            arith_q <= (i_alu_control == OP_SRA) | (i_alu_control == OP_SRAW);
                            w_q     <= is_w_shift_d;
                        end else
`endif
                        begin
                            state_q  <= ST_DONE;
                            valid_q  <= 1'b1;
                            result_q <= alu_res_d;
                            zero_q   <= (alu_res_d == 64'd0);
                        end
                    end else if ((state_q == ST_DONE) && i_ready) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end
                end
`ifndef ALU_FAST_SHIFT_EN
                ST_SHIFT: begin
                    work_q <= step_d;
                    cnt_q  <= cnt_q - 6'd1;
                    if (cnt_q == 6'd1) begin
                        state_q  <= ST_DONE;
                        valid_q  <= 1'b1;
                        result_q <= step_final_d;
                        zero_q   <= (step_final_d == 64'd0);
                    end
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
